sha_block_assembler: RTL and testbench

SHA_BLOCK_ASSEMBLER -- requirements
Module: sha_block_assembler

---
 rtl/sha_block_assembler.sv | 152 +++++++++++++++
 tb/tb_sha_block_assembler.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/sha_block_assembler.sv
// sha_block_assembler
//   Packs a byte stream, such as the output of a UART receiver, into fixed-size
//   blocks for a SHA core. The design has one fill register and one output slot,
//   so the next block can fill while the consumer still holds the current one.
//   A partial block can be dropped by an idle timeout or by clr.
//
// Parameters
//   BLOCK_BYTES    bytes per block (1..128)
//   MSB_FIRST      1: byte 0 goes in the top byte of blk_data; 0: byte 0 goes in bits [7:0]
//   TIMEOUT_CYCLES idle cycles before a partial block is discarded (0 = off)
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   in_valid/in_byte  one-cycle byte strobe; there is no backpressure
//   clr             synchronous flush of the partial block and of ovf_err
//   blk_data/blk_valid/blk_ready  output slot with a valid/ready handshake
//   byte_cnt        bytes held in the fill register
//   blk_count       blocks delivered to the slot (wraps)
//   ovf_err         sticky: a byte was dropped while a full block was waiting
//   timeout_pulse   one-cycle pulse when a partial block times out
module sha_block_assembler #(
    parameter int unsigned BLOCK_BYTES    = 64,
    parameter bit          MSB_FIRST      = 1'b1,
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [7:0]               in_byte,
    input  logic                     clr,
    output logic [BLOCK_BYTES*8-1:0] blk_data,
    output logic                     blk_valid,
    input  logic                     blk_ready,
    output logic [7:0]               byte_cnt,
    output logic [15:0]              blk_count,
    output logic                     ovf_err,
    output logic                     timeout_pulse
);

    localparam int unsigned W          = BLOCK_BYTES * 8;
    localparam logic [7:0]  LAST_IDX   = 8'(BLOCK_BYTES - 1);
    localparam logic [7:0]  FULL_CNT   = 8'(BLOCK_BYTES);
    localparam bit          TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [31:0] TO_LAST    = TIMEOUT_EN ? 32'(TIMEOUT_CYCLES - 1) : 32'd0;

    typedef enum logic {
        ST_FILL,
        ST_FULL
    } state_t;

    state_t         state, state_n;
    logic [W-1:0]   fill_reg, fill_n, placed, data_n;
    logic [7:0]     cnt_n;
    logic [15:0]    count_n;
    logic [31:0]    idle_cnt, idle_n;
    logic           valid_n, ovf_n, pulse_n, slot_free;

    assign slot_free = !blk_valid || blk_ready;

    // The fill register with in_byte written at position byte_cnt.
    for (genvar g = 0; g < BLOCK_BYTES; g++) begin : g_place
        localparam int unsigned LO = MSB_FIRST ? (W - 8 - 8 * g) : (8 * g);
        assign placed[LO +: 8] = (byte_cnt == 8'(g)) ? in_byte : fill_reg[LO +: 8];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_FILL;
            fill_reg      <= '0;
            byte_cnt      <= '0;
            blk_data      <= '0;
            blk_valid     <= 1'b0;
            blk_count     <= '0;
            ovf_err       <= 1'b0;
            timeout_pulse <= 1'b0;
            idle_cnt      <= '0;
        end else begin
            state         <= state_n;
            fill_reg      <= fill_n;
            byte_cnt      <= cnt_n;
            blk_data      <= data_n;
            blk_valid     <= valid_n;
            blk_count     <= count_n;
            ovf_err       <= ovf_n;
            timeout_pulse <= pulse_n;
            idle_cnt      <= idle_n;
        end
    end

    always_comb begin
        state_n = state;
        fill_n  = fill_reg;
        cnt_n   = byte_cnt;
        data_n  = blk_data;
        // The slot empties on a handshake unless a new block is loaded below.
        valid_n = blk_valid && !blk_ready;
        count_n = blk_count;
        ovf_n   = ovf_err;
        pulse_n = 1'b0;
        idle_n  = idle_cnt;

        if (clr) begin
            // The handshake on the slot still completes. A byte that arrives with clr is dropped.
            state_n = ST_FILL;
            cnt_n   = '0;
            idle_n  = '0;
            ovf_n   = 1'b0;
        end else begin
            unique case (state)
                ST_FILL: begin
                    if (in_valid) begin
                        fill_n = placed;
                        idle_n = '0;
                        if (byte_cnt == LAST_IDX) begin
                            if (slot_free) begin
                                data_n  = placed;
                                valid_n = 1'b1;
                                count_n = blk_count + 16'd1;
                                cnt_n   = '0;
                            end else begin
                                state_n = ST_FULL;
                                cnt_n   = FULL_CNT;
                            end
                        end else begin
                            cnt_n = byte_cnt + 8'd1;
                        end
                    end else if (TIMEOUT_EN && byte_cnt != 8'd0) begin
                        if (idle_cnt == TO_LAST) begin
                            cnt_n   = '0;
                            idle_n  = '0;
                            pulse_n = 1'b1;
                        end else begin
                            idle_n = idle_cnt + 32'd1;
                        end
                    end
                end
                ST_FULL: begin
                    if (in_valid) ovf_n = 1'b1;
                    if (slot_free) begin
                        data_n  = fill_reg;
                        valid_n = 1'b1;
                        count_n = blk_count + 16'd1;
                        cnt_n   = '0;
                        state_n = ST_FILL;
                    end
                end
                default: state_n = ST_FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_sha_block_assembler.sv
module tb_sha_block_assembler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // u_def: default parameters (64 bytes, MSB first)
    logic         rst_a, iv0, clr0, br0, bv0, ovf0, tp0;
    logic [7:0]   ib0, cnt0;
    logic [511:0] bd0;
    logic [15:0]  bc0;
    // u_le4: 4 bytes, LSB first
    logic         rst_b, iv1, clr1, br1, bv1, ovf1, tp1;
    logic [7:0]   ib1, cnt1;
    logic [31:0]  bd1;
    logic [15:0]  bc1;
    // u_to: 8 bytes, timeout 10
    logic         iv2, clr2, br2, bv2, ovf2, tp2;
    logic [7:0]   ib2, cnt2;
    logic [63:0]  bd2;
    logic [15:0]  bc2;

    sha_block_assembler u_def (
        .clk(clk), .rst(rst_a), .in_valid(iv0), .in_byte(ib0), .clr(clr0),
        .blk_data(bd0), .blk_valid(bv0), .blk_ready(br0), .byte_cnt(cnt0),
        .blk_count(bc0), .ovf_err(ovf0), .timeout_pulse(tp0)
    );

    sha_block_assembler #(.BLOCK_BYTES(4), .MSB_FIRST(1'b0)) u_le4 (
        .clk(clk), .rst(rst_b), .in_valid(iv1), .in_byte(ib1), .clr(clr1),
        .blk_data(bd1), .blk_valid(bv1), .blk_ready(br1), .byte_cnt(cnt1),
        .blk_count(bc1), .ovf_err(ovf1), .timeout_pulse(tp1)
    );

    sha_block_assembler #(.BLOCK_BYTES(8), .TIMEOUT_CYCLES(10)) u_to (
        .clk(clk), .rst(rst_b), .in_valid(iv2), .in_byte(ib2), .clr(clr2),
        .blk_data(bd2), .blk_valid(bv2), .blk_ready(br2), .byte_cnt(cnt2),
        .blk_count(bc2), .ovf_err(ovf2), .timeout_pulse(tp2)
    );

    typedef struct {
        logic [31:0] bytes;   // byte 0 in [31:24]
        logic [31:0] exp;
    } vec_t;

    vec_t         vecs[4];
    logic [511:0] sb_q[$];
    logic [511:0] exp_blk;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one byte on DUT d. The task is entered at posedge+1 and returns at posedge+1.
    task automatic send(input int d, input logic [7:0] b);
        case (d)
            0: begin iv0 = 1'b1; ib0 = b; end
            1: begin iv1 = 1'b1; ib1 = b; end
            default: begin iv2 = 1'b1; ib2 = b; end
        endcase
        @(posedge clk); #1;
        iv0 = 1'b0; iv1 = 1'b0; iv2 = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    initial begin
        int n;
        vecs[0] = '{32'h11223344, 32'h44332211};
        vecs[1] = '{32'hAABBCCDD, 32'hDDCCBBAA};
        vecs[2] = '{32'h01020304, 32'h04030201};
        vecs[3] = '{32'hFF00FF00, 32'h00FF00FF};

        rst_a = 1'b1; rst_b = 1'b1;
        iv0 = 0; ib0 = 0; clr0 = 0; br0 = 1;
        iv1 = 0; ib1 = 0; clr1 = 0; br1 = 1;
        iv2 = 0; ib2 = 0; clr2 = 0; br2 = 1;
        repeat (3) @(posedge clk);
        #1;
        rst_a = 1'b0; rst_b = 1'b0;

        check("rst_valid", 512'(bv0), 0);
        check("rst_data", bd0, 0);
        check("rst_counts", {bc0, cnt0, ovf0, tp0}, 0);

        // Scoreboard: each transfer on u_def (valid & ready at negedge) pops one expected block.
        fork
            forever begin
                @(negedge clk);
                if (!rst_a && bv0 && br0) begin
                    if (sb_q.size() == 0) begin
                        tests++; fails++;
                        $display("FAIL sb_unexpected: got block %0h expected none", bd0);
                    end else begin
                        check("sb_block", bd0, sb_q.pop_front());
                    end
                end
            end
        join_none

        // Bytes 0x00..0x3F on the 64-byte default instance.
        exp_blk = '0;
        for (int k = 0; k < 64; k++) exp_blk[511 - 8*k -: 8] = 8'(k);
        for (int k = 0; k < 64; k++) begin
            if (k == 63) begin
                check("no_early_valid", 512'(bv0), 0);
                sb_q.push_back(exp_blk);
            end
            send(0, 8'(k));
        end
        check("b64_valid", 512'(bv0), 1);
        check("b64_top", 512'(bd0[511:504]), 512'h00);
        check("b64_low", 512'(bd0[7:0]), 512'h3F);
        check("b64_count", 512'(bc0), 1);
        check("b64_cnt", 512'(cnt0), 0);
        tick();
        check("b64_drained", 512'(bv0), 0);

        // Reset after 30 bytes, then a fresh block.
        for (int k = 0; k < 30; k++) send(0, 8'(8'hA0 + k));
        check("mid_cnt", 512'(cnt0), 30);
        rst_a = 1'b1;
        tick();
        rst_a = 1'b0;
        check("mid_rst_data", bd0, 0);
        check("mid_rst_misc", {bv0, bc0, cnt0, ovf0, tp0}, 0);
        for (int k = 0; k < 64; k++) exp_blk[511 - 8*k -: 8] = 8'(8'h40 + k);
        for (int k = 0; k < 64; k++) begin
            if (k == 63) sb_q.push_back(exp_blk);
            send(0, 8'(8'h40 + k));
        end
        check("post_rst_count", 512'(bc0), 1);

        // clr together with a byte after 5 bytes.
        for (int k = 0; k < 5; k++) send(0, 8'(8'hE0 + k));
        clr0 = 1'b1; iv0 = 1'b1; ib0 = 8'hEE;
        tick();
        clr0 = 1'b0; iv0 = 1'b0;
        check("clr_cnt", 512'(cnt0), 0);
        check("clr_ovf", 512'(ovf0), 0);
        for (int k = 0; k < 64; k++) exp_blk[511 - 8*k -: 8] = 8'(8'hC0 + k);
        for (int k = 0; k < 64; k++) begin
            if (k == 63) sb_q.push_back(exp_blk);
            send(0, 8'(8'hC0 + k));
        end
        check("post_clr_count", 512'(bc0), 2);
        tick(); tick();
        check("sb_drained", 512'(sb_q.size()), 0);

        // Table of 4-byte LSB-first vectors.
        for (int v = 0; v < 4; v++) begin
            for (int k = 0; k < 4; k++) send(1, vecs[v].bytes[31 - 8*k -: 8]);
            check("le4_valid", 512'(bv1), 1);
            check("le4_data", 512'(bd1), 512'(vecs[v].exp));
            check("le4_count", 512'(bc1), 512'(v + 1));
        end
        tick();

        // Consumer stalled: the second block waits in FULL and the ninth byte is dropped.
        br1 = 1'b0;
        for (int k = 1; k <= 8; k++) send(1, 8'(k));
        check("stall_hold", 512'(bd1), 512'h04030201);
        check("stall_full_cnt", 512'(cnt1), 4);
        check("stall_no_ovf", 512'(ovf1), 0);
        send(1, 8'h09);
        check("stall_ovf", 512'(ovf1), 1);
        check("stall_cnt_kept", 512'(cnt1), 4);
        check("stall_hold2", 512'(bd1), 512'h04030201);
        br1 = 1'b1;
        tick();
        check("release_valid", 512'(bv1), 1);
        check("release_data", 512'(bd1), 512'h08070605);
        check("release_count", 512'(bc1), 6);
        check("release_cnt", 512'(cnt1), 0);
        tick();
        check("release_drained", 512'(bv1), 0);
        for (int k = 0; k < 4; k++) send(1, 8'(8'h0A + k));
        check("after_drop_data", 512'(bd1), 512'h0D0C0B0A);
        clr1 = 1'b1;
        tick();
        clr1 = 1'b0;
        check("clr_clears_ovf", 512'(ovf1), 0);

        // Timeout: the pulse appears 10 cycles after the last byte.
        for (int k = 0; k < 3; k++) send(2, 8'(k));
        n = 31;
        for (int c = 1; c <= 30; c++) begin
            tick();
            if (tp2) begin n = c; break; end
        end
        check("to_latency", 512'(n), 10);
        check("to_cnt", 512'(cnt2), 0);
        check("to_slot", 512'(bv2), 0);
        tick();
        check("to_one_cycle", 512'(tp2), 0);

        // A byte in the expiring cycle suppresses the timeout.
        send(2, 8'h51); send(2, 8'h52);
        repeat (9) tick();
        check("pre_expire_cnt", 512'(cnt2), 2);
        send(2, 8'h55);
        check("expire_no_pulse", 512'(tp2), 0);
        check("expire_byte_taken", 512'(cnt2), 3);
        n = 31;
        for (int c = 1; c <= 30; c++) begin
            tick();
            if (tp2) begin n = c; break; end
        end
        check("to_restart", 512'(n), 10);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
